// File: rtl/nes_timing_pkg.sv
// nes_timing_pkg: divider constants (NTSC by default, PAL when NES_PAL_TIMING_EN is defined) and FSM states
package nes_timing_pkg;
`ifdef NES_PAL_TIMING_EN
    localparam int PPU_DIV = 5;
    localparam int CPU_DIV = 16;
    localparam int M2_RISE = 6;
`else
    localparam int PPU_DIV = 4;
    localparam int CPU_DIV = 12;
    localparam int M2_RISE = 5;
`endif
    localparam int PPU_W = $clog2(PPU_DIV);
    localparam int CPU_W = $clog2(CPU_DIV);
    typedef enum logic [1:0] {RUN, DRAIN, PAUSED, STEP} state_t;
endpackage

// File: rtl/nes_timing_gen_if.sv
// nes_timing_gen_if: run/step controls and timing outputs of nes_timing_gen
interface nes_timing_gen_if #(
    parameter int CYC_W = 16
);
    logic             run, step, ppu_ce, cpu_ce, m2, cpu_odd, paused;
    logic [CYC_W-1:0] cpu_cycles;
    modport master (input run, step, output ppu_ce, cpu_ce, m2, cpu_odd, cpu_cycles, paused);
    modport slave  (output run, step, input ppu_ce, cpu_ce, m2, cpu_odd, cpu_cycles, paused);
endinterface

// File: rtl/nes_mod_counter.sv
// nes_mod_counter: modulo-N counter that advances only when enabled, with terminal-count decode
module nes_mod_counter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] count,
    output logic         tc
);
    // terminal count is decoded from the registered value
    always_comb tc = count == W'(N - 1);
    // wrap to zero after the terminal count, hold when not advancing
    always_ff @(posedge clk) count <= reset ? '0 : adv ? (tc ? '0 : count + W'(1)) : count;
endmodule

// File: rtl/nes_timing_gen.sv
// nes_timing_gen: NES master-clock divider (PPU/CPU enables, M2, cycle count) with pause/step on aligned groups; NES_PAL_TIMING_EN selects PAL dividers
module nes_timing_gen
    import nes_timing_pkg::*;
#(
    parameter int CYC_W = 16
) (
    input logic              clk,
    input logic              reset,
    nes_timing_gen_if.master bus
);
    state_t           state, nstate;
    logic             adv, ppu_tc, cpu_tc, cpu_ce, boundary, m2, cpu_odd;
    logic [PPU_W-1:0] ppu_div;
    logic [CPU_W-1:0] cpu_div;
    logic [CYC_W-1:0] cycles;

    nes_mod_counter #(.N(PPU_DIV)) u_ppu (
        .clk(clk), .reset(reset), .adv(adv), .count(ppu_div), .tc(ppu_tc)
    );

    nes_mod_counter #(.N(CPU_DIV)) u_cpu (
        .clk(clk), .reset(reset), .adv(adv), .count(cpu_div), .tc(cpu_tc)
    );

    // next state and decoded outputs; a pause can only start on a group boundary so both dividers sit at 0 while paused
    always_comb begin
        nstate       = state;
        adv          = state != PAUSED;
        boundary     = ppu_tc && cpu_tc;
        cpu_ce       = cpu_tc && adv;
        case (state)
            RUN:     nstate = bus.run ? RUN : DRAIN;
            DRAIN:   nstate = bus.run ? RUN : boundary ? PAUSED : DRAIN;
            PAUSED:  nstate = bus.run ? RUN : bus.step ? STEP : PAUSED;
            STEP:    nstate = boundary ? (bus.run ? RUN : PAUSED) : STEP;
            default: nstate = RUN;
        endcase
        bus.ppu_ce     = ppu_tc && adv;
        bus.cpu_ce     = cpu_ce;
        bus.m2         = m2;
        bus.cpu_odd    = cpu_odd;
        bus.cpu_cycles = cycles;
        bus.paused     = state == PAUSED;
    end

    // state, M2 (registered from the next cpu_div so it tracks the count with no lag) and CPU cycle bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            m2      <= 1'b0;
            cpu_odd <= 1'b0;
            cycles  <= '0;
        end else begin
            state   <= nstate;
            m2      <= adv ? (!cpu_tc && cpu_div >= CPU_W'(M2_RISE - 1)) : m2;
            cpu_odd <= cpu_odd ^ cpu_ce;
            cycles  <= cpu_ce ? cycles + CYC_W'(1) : cycles;
        end
    end
endmodule
